instr_encoder_loader: RTL and testbench

Reverse of the control decoder. It accepts symbolic instruction requests (operation select plus register and immediate fields) over a valid/ready handshake. Each request is encoded into a 32-bit RV instruction word with the opcode/funct3/funct7 combinations the decoder recognises. The word is written sequentially into instruction memory. Used by the testbench/boot path to load programs into imem before the core is released from reset.

---
 rtl/instr_encoder_loader.sv | 173 +++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: turns symbolic instruction requests into 32-bit RV
// instruction words and streams them sequentially into instruction memory.
// The session runs IDLE -> LOAD -> DRAIN -> IDLE. One output register stage
// holds the word being written. It stays stable until imem accepts it.
//
// Handshakes:
//   request side: a request transfers on a clock edge where in_valid && in_ready.
//                 in_ready depends only on registered state and mem_ready.
//   imem side:    a write completes on a clock edge where mem_we && mem_ready.
//                 mem_we/mem_addr/mem_wdata do not change until then.
module instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [20:0]       in_imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic [7:0]        err_count,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_LD   = 7'b0000011;
  localparam logic [6:0] OPC_S    = 7'b0100011;
  localparam logic [6:0] OPC_B    = 7'b1100011;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;

  state_t              state_q;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [ADDR_W:0]     word_count_q, word_count_d;
  logic [7:0]          err_count_q, err_count_d;
  logic                done_q;
  logic [31:0]         enc_word;
  logic                wr_done;
  logic                accept;
  logic                legal;
  logic [ADDR_W:0]     committed;

  assign wr_done   = mem_we_q & mem_ready;
  // Words already written plus the one sitting in the output register.
  assign committed = word_count_q + {{ADDR_W{1'b0}}, mem_we_q};
  assign in_ready  = (state_q == S_LOAD) && (!mem_we_q || mem_ready) &&
                     (committed < DEPTH_C);
  assign accept    = in_valid & in_ready;
  assign legal     = (in_op != 4'd15);

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign word_count = word_count_q;
  assign err_count  = err_count_q;
  assign done       = done_q;
  assign busy       = (state_q != S_IDLE);
  assign state_dbg  = state_q;

  // Encode the request fields into a 32-bit instruction word by format.
  always_comb begin
    enc_word = '0;
    case (in_op)
      4'd0:  enc_word = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, OPC_R};
      4'd1:  enc_word = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, OPC_R};
      4'd2:  enc_word = {7'b0000000, in_rs2, in_rs1, 3'b111, in_rd, OPC_R};
      4'd3:  enc_word = {7'b0000000, in_rs2, in_rs1, 3'b110, in_rd, OPC_R};
      4'd4:  enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_I};
      4'd5:  enc_word = {in_imm[11:0], in_rs1, 3'b100, in_rd, OPC_I};
      4'd6:  enc_word = {7'b0000000, in_imm[4:0], in_rs1, 3'b001, in_rd, OPC_I};
      4'd7:  enc_word = {7'b0000000, in_imm[4:0], in_rs1, 3'b101, in_rd, OPC_I};
      4'd8:  enc_word = {7'b0100000, in_imm[4:0], in_rs1, 3'b101, in_rd, OPC_I};
      4'd9:  enc_word = {in_imm[11:0], in_rs1, 3'b011, in_rd, OPC_LD};
      4'd10: enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OPC_S};
      4'd11: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                         in_imm[4:1], in_imm[11], OPC_B};
      4'd12: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b001,
                         in_imm[4:1], in_imm[11], OPC_B};
      4'd13: enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_JALR};
      4'd14: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                         in_rd, OPC_JAL};
      default: enc_word = '0;
    endcase
  end

  // Next values for the write register, address, counters and error tally.
  always_comb begin
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    word_count_d = word_count_q;
    err_count_d  = err_count_q;
    if (wr_done) begin
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q + ADDR_W'(1);
      word_count_d = word_count_q + (ADDR_W+1)'(1);
    end
    if (accept) begin
      if (legal) begin
        mem_we_d    = 1'b1;
        mem_wdata_d = enc_word;
      end else if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
    if ((state_q == S_IDLE) && start) begin
      mem_addr_d   = '0;
      mem_word_clear_placeholder_unused: begin end
      word_count_d = '0;
    end
  end

  // Session FSM plus all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      word_count_q <= '0;
      err_count_q  <= '0;
      done_q       <= 1'b0;
    end else begin
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      word_count_q <= word_count_d;
      err_count_q  <= err_count_d;
      done_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) state_q <= S_LOAD;
        end
        S_LOAD: begin
          if (finish ||
              ((word_count_d + {{ADDR_W{1'b0}}, mem_we_d}) >= DEPTH_C)) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!mem_we_d) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed scenarios with literal words plus
// randomized sessions checked against a format-table encoder and write queue.
module tb_instr_encoder_loader;

  localparam int ADDR_W = 8;
  localparam int EW     = ADDR_W + 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT signals ----------------
  logic              start = 0, finish = 0, in_valid = 0;
  logic              in_ready;
  logic [3:0]        in_op = 0;
  logic [4:0]        in_rd = 0, in_rs1 = 0, in_rs2 = 0;
  logic [20:0]       in_imm = 0;
  logic              mem_we, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy, done;
  logic [ADDR_W:0]   word_count;
  logic [7:0]        err_count;
  logic [1:0]        state_dbg;
  logic              rand_rdy = 0, dir_rdy = 1, rnd_rdy = 1;
  assign mem_ready = rand_rdy ? rnd_rdy : dir_rdy;
  always @(negedge clk) rnd_rdy = ($urandom_range(0, 3) != 0);

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .mem_we(mem_we),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .word_count(word_count), .err_count(err_count),
    .state_dbg(state_dbg));

  // Small-depth instance for the session-full boundary.
  logic              start4 = 0, valid4 = 0, finish4 = 0, mem_ready4 = 1;
  logic              in_ready4, mem_we4, busy4, done4;
  logic [ADDR_W-1:0] mem_addr4;
  logic [31:0]       mem_wdata4;
  logic [ADDR_W:0]   wc4;
  logic [7:0]        err4;
  logic [1:0]        st4;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .finish(finish4),
    .in_valid(valid4), .in_ready(in_ready4), .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .mem_we(mem_we4),
    .mem_ready(mem_ready4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .busy(busy4), .done(done4), .word_count(wc4), .err_count(err4),
    .state_dbg(st4));

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference encoder: field placement by instruction format.
  function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [20:0] imm);
    logic [31:0] i, o, f3, f7, r;
    int fmt; // 0 R, 1 I, 2 shift, 3 S, 4 B, 5 J
    i = {11'b0, imm}; o = 0; f3 = 0; f7 = 0; fmt = 0;
    case (op)
      4'd0:  begin o = 32'h33; f3 = 0; f7 = 32'h00; fmt = 0; end
      4'd1:  begin o = 32'h33; f3 = 0; f7 = 32'h20; fmt = 0; end
      4'd2:  begin o = 32'h33; f3 = 7; fmt = 0; end
      4'd3:  begin o = 32'h33; f3 = 6; fmt = 0; end
      4'd4:  begin o = 32'h13; f3 = 0; fmt = 1; end
      4'd5:  begin o = 32'h13; f3 = 4; fmt = 1; end
      4'd6:  begin o = 32'h13; f3 = 1; f7 = 32'h00; fmt = 2; end
      4'd7:  begin o = 32'h13; f3 = 5; f7 = 32'h00; fmt = 2; end
      4'd8:  begin o = 32'h13; f3 = 5; f7 = 32'h20; fmt = 2; end
      4'd9:  begin o = 32'h03; f3 = 3; fmt = 1; end
      4'd10: begin o = 32'h23; f3 = 2; fmt = 3; end
      4'd11: begin o = 32'h63; f3 = 0; fmt = 4; end
      4'd12: begin o = 32'h63; f3 = 1; fmt = 4; end
      4'd13: begin o = 32'h67; f3 = 0; fmt = 1; end
      4'd14: begin o = 32'h6F; fmt = 5; end
      default: fmt = 6;
    endcase
    case (fmt)
      0: r = (f7 << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (f3 << 12) | (32'(rd) << 7) | o;
      1: r = ((i & 32'hFFF) << 20) | (32'(rs1) << 15) | (f3 << 12) | (32'(rd) << 7) | o;
      2: r = (f7 << 25) | ((i & 32'h1F) << 20) | (32'(rs1) << 15) | (f3 << 12) | (32'(rd) << 7) | o;
      3: r = (((i >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (f3 << 12)
             | ((i & 32'h1F) << 7) | o;
      4: r = (((i >> 12) & 1) << 31) | (((i >> 5) & 32'h3F) << 25) | (32'(rs2) << 20)
             | (32'(rs1) << 15) | (f3 << 12) | (((i >> 1) & 32'hF) << 8) | (((i >> 11) & 1) << 7) | o;
      5: r = (((i >> 20) & 1) << 31) | (((i >> 1) & 32'h3FF) << 21) | (((i >> 11) & 1) << 20)
             | (((i >> 12) & 32'hFF) << 12) | (32'(rd) << 7) | o;
      default: r = 0;
    endcase
    return r;
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];
  int            obs_cyc[$];
  logic [EW-1:0] hold, e;
  logic          stall_prev = 0;
  logic          acc_flag = 0;
  int            m_addr = 0, m_words = 0, m_err = 0;

  // Sampled just before each rising edge, when inputs and outputs are settled.
  always @(negedge clk) begin
    #4;
    acc_flag = in_valid && in_ready;
    if (!rst_n) begin
      exp_q.delete();
      m_err = 0; m_addr = 0; m_words = 0; stall_prev = 0;
    end else begin
      if (stall_prev)
        chk("stall_hold", {mem_we, mem_addr, mem_wdata}, {1'b1, hold});
      if (mem_we && mem_ready) begin
        obs_q.push_back({mem_addr, mem_wdata});
        obs_cyc.push_back(cyc);
        if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("write", {mem_addr, mem_wdata}, e);
        end
      end
      stall_prev = mem_we && !mem_ready;
      hold = {mem_addr, mem_wdata};
      if (start) begin m_addr = 0; m_words = 0; end
      if (acc_flag) begin
        if (in_op != 4'd15) begin
          exp_q.push_back({ADDR_W'(m_addr), enc(in_op, in_rd, in_rs1, in_rs2, in_imm)});
          m_addr++; m_words++;
        end else if (m_err < 255) m_err++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [20:0] imm);
    @(negedge clk);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_valid = 1;
  endtask

  task automatic wait_accept();
    bit got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk);
      if (acc_flag) got = 1;
    end
    chk("accept", got, 1);
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [20:0] imm);
    drive_req(op, rd, rs1, rs2, imm);
    wait_accept();
  endtask

  task automatic idle_in();
    @(negedge clk); in_valid = 0;
  endtask

  task automatic do_start();
    @(negedge clk); in_valid = 0; start = 1;
    obs_q.delete(); obs_cyc.delete();
    @(negedge clk); start = 0;
  endtask

  task automatic do_finish();
    @(negedge clk); in_valid = 0; finish = 1;
    @(negedge clk); finish = 0;
  endtask

  task automatic wait_done(input string name, input int exp_wc);
    bit got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk); #1;
      if (done) got = 1;
    end
    chk({name, "_done"}, got, 1);
    chk({name, "_wc"}, word_count, exp_wc);
    chk({name, "_busy"}, busy, 0);
    @(negedge clk); #1;
    chk({name, "_done_pulse"}, done, 0);
    chk({name, "_pending"}, exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] q4[$];
    int acc4, wr4, dn4, k;
    int wd;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_we", mem_we, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_busy_done", {busy, done}, 0);
    chk("rst_counts", {word_count, err_count, mem_addr}, 0);
    chk("rst_wdata", mem_wdata, 0);
    rst_n = 1;

    // Single ADD.
    do_start();
    send(4'd0, 5'd3, 5'd1, 5'd2, 21'd0);
    do_finish();
    wait_done("t1", 1);
    chk("t1_word", obs_q[0], {8'd0, 32'h002081B3});

    // ADDI then SW back to back, finish on the SW accept cycle.
    do_start();
    send(4'd4, 5'd5, 5'd0, 5'd0, 21'h1FFFFF);
    drive_req(4'd10, 5'd7, 5'd1, 5'd2, 21'd8);
    finish = 1;
    wait_accept();
    @(negedge clk); finish = 0; in_valid = 0;
    wait_done("t2", 2);
    chk("t2_w0", obs_q[0], {8'd0, 32'hFFF00293});
    chk("t2_w1", obs_q[1], {8'd1, 32'h0020A423});
    chk("t2_consec", obs_cyc[1] - obs_cyc[0], 1);

    // BEQ, SRAI, JAL.
    do_start();
    send(4'd11, 5'd9, 5'd1, 5'd2, 21'd16);
    send(4'd8, 5'd4, 5'd4, 5'd17, 21'd3);
    send(4'd14, 5'd1, 5'd6, 5'd7, 21'd8);
    do_finish();
    wait_done("t3", 3);
    chk("t3_w0", obs_q[0], {8'd0, 32'h00208863});
    chk("t3_w1", obs_q[1], {8'd1, 32'h40325213});
    chk("t3_w2", obs_q[2], {8'd2, 32'h008000EF});

    // Stall: imem not ready for three cycles with a word pending.
    dir_rdy = 0;
    do_start();
    send(4'd1, 5'd7, 5'd8, 5'd9, 21'd0);
    drive_req(4'd2, 5'd10, 5'd11, 5'd12, 21'd0);
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("t4_ready_low", in_ready, 0);
      chk("t4_hold", {mem_we, mem_addr, mem_wdata}, {1'b1, 8'd0, 32'h409403B3});
      @(negedge clk);
    end
    dir_rdy = 1;
    wait_accept();
    do_finish();
    wait_done("t4", 2);
    chk("t4_w1_addr", obs_q[1][EW-1:32], 1);

    // Illegal request mid-stream.
    do_start();
    send(4'd4, 5'd1, 5'd2, 5'd0, 21'd100);
    send(4'd15, 5'd3, 5'd4, 5'd5, 21'd7);
    send(4'd5, 5'd6, 5'd7, 5'd0, 21'h1FF800);
    do_finish();
    wait_done("t5", 2);
    chk("t5_err", err_count, 1);
    chk("t5_w1_addr", obs_q[1][EW-1:32], 1);

    // Reset with a write pending.
    dir_rdy = 0;
    do_start();
    send(4'd3, 5'd1, 5'd2, 5'd3, 21'd0);
    @(negedge clk); in_valid = 0; rst_n = 0;
    @(negedge clk); #1;
    chk("t6_we", mem_we, 0);
    chk("t6_busy", busy, 0);
    chk("t6_counts", {word_count, err_count}, 0);
    rst_n = 1; dir_rdy = 1;

    // Session-full boundary on the depth-4 instance: six requests offered.
    @(negedge clk); start4 = 1;
    @(negedge clk); start4 = 0;
    acc4 = 0; wr4 = 0; dn4 = 0; k = 0;
    for (int i = 0; i < 14; i++) begin
      if (i > 0) @(negedge clk);
      if (k < 6) begin
        in_op = (k % 2) ? 4'd5 : 4'd4;
        in_rd = 5'(k + 1); in_rs1 = 5'(k + 2); in_rs2 = 5'd0; in_imm = 21'(k * 5 + 1);
        valid4 = 1;
      end else valid4 = 0;
      #4;
      if (mem_we4) begin
        chk("t7_addr", mem_addr4, wr4);
        if (q4.size() == 0) chk("t7_unexpected", 1, 0);
        else chk("t7_data", mem_wdata4, q4.pop_front());
        wr4++;
      end
      if (done4) dn4++;
      if (valid4 && in_ready4) begin
        q4.push_back(enc(in_op, in_rd, in_rs1, in_rs2, in_imm));
        acc4++; k++;
      end
    end
    valid4 = 0;
    chk("t7_accepts", acc4, 4);
    chk("t7_writes", wr4, 4);
    chk("t7_done", dn4, 1);
    chk("t7_wc", wc4, 4);
    chk("t7_busy", busy4, 0);

    // Randomized sessions with random imem backpressure.
    rand_rdy = 1;
    for (int s = 0; s < 4; s++) begin
      do_start();
      for (int r = 0; r < 25; r++) begin
        if ($urandom_range(0, 3) == 0) idle_in();
        send(4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom), 21'($urandom));
      end
      wd = m_words;
      do_finish();
      wait_done("rnd", wd);
      chk("rnd_err", err_count, m_err);
    end
    rand_rdy = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
